// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: point-size mode encodings,
// framer state encodings and the mapping from mode to frame length.
package fft_pkg;

    localparam logic [2:0] MODE64  = 3'b001;
    localparam logic [2:0] MODE256 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } framer_state_e;

    function automatic logic [9:0] mode_to_n(input logic [2:0] mode);
        return (mode == MODE64) ? 10'd64 : 10'd256;
    endfunction

endpackage

// File: rtl/fft_input_framer.sv
// Frames a stream of ADC samples into fixed-length FFT input frames, zero
// padding a frame whose samples stop arriving, and sequencing multi-frame bursts.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       cfg_mode,
    input  logic [7:0]       cfg_frames,
    input  logic             start,
    input  logic             stop,
    input  logic             adc_valid,
    input  logic [WIDTH-1:0] adc_re,
    input  logic [WIDTH-1:0] adc_im,
    output logic [2:0]       mode_di_sel,
    output logic             data_di_en,
    output logic [WIDTH-1:0] data_di_re,
    output logic [WIDTH-1:0] data_di_im,
    output logic             frame_sof,
    output logic             frame_eof,
    output logic             busy,
    output logic             done,
    output logic             pad_flag,
    output logic             err_mode,
    output logic [7:0]       frame_cnt,
    output logic [1:0]       dbg_state
);

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    framer_state_e    state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [7:0]       frames_q, frames_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [9:0]       samp_cnt_q, samp_cnt_d;
    logic [15:0]      idle_q, idle_d;
    logic             stop_pend_q, stop_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pad_flag_q, pad_flag_d;
    logic             err_mode_q, err_mode_d;
    logic             data_di_en_q, data_di_en_d;
    logic             frame_sof_q, frame_sof_d;
    logic             frame_eof_q, frame_eof_d;
    logic [WIDTH-1:0] data_di_re_q, data_di_re_d;
    logic [WIDTH-1:0] data_di_im_q, data_di_im_d;
    logic [9:0]       last_idx;
    logic             emit;

    assign last_idx = mode_to_n(mode_q) - 10'd1;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        frames_d     = frames_q;
        frame_cnt_d  = frame_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        idle_d       = idle_q;
        stop_pend_d  = stop_pend_q;
        busy_d       = busy_q;
        pad_flag_d   = pad_flag_q;
        err_mode_d   = err_mode_q;
        done_d       = 1'b0;
        data_di_en_d = 1'b0;
        frame_sof_d  = 1'b0;
        frame_eof_d  = 1'b0;
        data_di_re_d = '0;
        data_di_im_d = '0;
        emit         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Unsupported point sizes fall back to 256 and are flagged.
                    if (cfg_mode == MODE64 || cfg_mode == MODE256) begin
                        mode_d     = cfg_mode;
                        err_mode_d = 1'b0;
                    end else begin
                        mode_d     = MODE256;
                        err_mode_d = 1'b1;
                    end
                    frames_d    = cfg_frames;
                    frame_cnt_d = '0;
                    samp_cnt_d  = '0;
                    idle_d      = '0;
                    stop_pend_d = 1'b0;
                    pad_flag_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (adc_valid) begin
                    emit         = 1'b1;
                    data_di_re_d = adc_re;
                    data_di_im_d = adc_im;
                    idle_d       = '0;
                end else if (samp_cnt_q != 10'd0) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d    = ST_PAD;
                        pad_flag_d = 1'b1;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end
            end
            ST_PAD: begin
                if (stop) stop_pend_d = 1'b1;
                emit = 1'b1;
            end
            ST_DRAIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared sample emission for real and padded samples; a stop arriving
        // with the last sample still ends the burst on this frame.
        if (emit) begin
            data_di_en_d = 1'b1;
            frame_sof_d  = (samp_cnt_q == 10'd0);
            frame_eof_d  = (samp_cnt_q == last_idx);
            if (samp_cnt_q == last_idx) begin
                samp_cnt_d  = '0;
                idle_d      = '0;
                frame_cnt_d = frame_cnt_q + 8'd1;
                if ((frames_q != 8'd0 && frame_cnt_d == frames_q) || stop_pend_d)
                    state_d = ST_DRAIN;
                else
                    state_d = ST_RUN;
            end else begin
                samp_cnt_d = samp_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE256;
            frames_q     <= '0;
            frame_cnt_q  <= '0;
            samp_cnt_q   <= '0;
            idle_q       <= '0;
            stop_pend_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pad_flag_q   <= 1'b0;
            err_mode_q   <= 1'b0;
            data_di_en_q <= 1'b0;
            frame_sof_q  <= 1'b0;
            frame_eof_q  <= 1'b0;
            data_di_re_q <= '0;
            data_di_im_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            frames_q     <= frames_d;
            frame_cnt_q  <= frame_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            idle_q       <= idle_d;
            stop_pend_q  <= stop_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pad_flag_q   <= pad_flag_d;
            err_mode_q   <= err_mode_d;
            data_di_en_q <= data_di_en_d;
            frame_sof_q  <= frame_sof_d;
            frame_eof_q  <= frame_eof_d;
            data_di_re_q <= data_di_re_d;
            data_di_im_q <= data_di_im_d;
        end
    end

    assign mode_di_sel = mode_q;
    assign data_di_en  = data_di_en_q;
    assign data_di_re  = data_di_re_q;
    assign data_di_im  = data_di_im_q;
    assign frame_sof   = frame_sof_q;
    assign frame_eof   = frame_eof_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pad_flag    = pad_flag_q;
    assign err_mode    = err_mode_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state   = state_q;

endmodule
